// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: counter-width helper, default clock frequency, receiver FSM encoding.
`timescale 1ns/1ps
package uart_rx_pkg;

    localparam int UART_CLK_FREQ_DEFAULT = 50_000_000;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int clogb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an idle-high asynchronous input, plus a registered copy for edge detection.
`timescale 1ns/1ps
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic fall_edge
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], d};
        end
    end

    // fall_edge is high the cycle before q itself goes low.
    assign q         = sync_q[2];
    assign fall_edge = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, datawidth data bits LSB first, 1 stop, no parity, mid-bit sampling.
// Define UART_RX_MAJORITY_EN to use a 2-of-3 vote around mid-bit (decision one cycle later).
`timescale 1ns/1ps
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int datawidth = 8,
    parameter int Baudrate  = 9600,
    parameter int CLK_FREQ  = UART_CLK_FREQ_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [datawidth-1:0] data_out,
    output logic                 rx_done_flag,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int BIT_CYC  = CLK_FREQ / Baudrate;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CW       = clogb2(BIT_CYC);
    localparam int IW       = clogb2(datawidth);
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_LAT = 1;
`else
    localparam int SAMPLE_LAT = 0;
`endif
    localparam logic [CW-1:0] START_PT = CW'(HALF_CYC - 1 + SAMPLE_LAT);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(datawidth - 1);

    rx_state_t            state, state_nxt;
    logic [CW-1:0]        bit_cyc_cnt;
    logic [IW-1:0]        bit_idx;
    logic [datawidth-1:0] shreg;
    logic                 rxd_s, fall_edge, sample_bit;
    logic                 cnt_clr, idx_clr, idx_inc, shift_en, done_set, err_set;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (rxd),
        .q         (rxd_s),
        .fall_edge (fall_edge)
    );

`ifdef UART_RX_MAJORITY_EN
    // hist[1], hist[0], rxd_s are the samples at mid-1, mid, mid+1 when the decision is taken.
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rxd_s};
        end
    end

    assign sample_bit = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
`else
    assign sample_bit = rxd_s;
`endif

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        shift_en  = 1'b0;
        done_set  = 1'b0;
        err_set   = 1'b0;
        case (state)
            RX_IDLE: begin
                if (fall_edge) begin
                    state_nxt = RX_START;
                    cnt_clr   = 1'b1;
                end
            end
            RX_START: begin
                if (bit_cyc_cnt == START_PT) begin
                    cnt_clr = 1'b1;
                    if (!sample_bit) begin
                        state_nxt = RX_DATA;
                        idx_clr   = 1'b1;
                    end else begin
                        state_nxt = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (bit_cyc_cnt == BIT_LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == IDX_LAST) begin
                        state_nxt = RX_STOP;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (bit_cyc_cnt == BIT_LAST) begin
                    cnt_clr = 1'b1;
                    if (sample_bit) begin
                        done_set  = 1'b1;
                        state_nxt = RX_IDLE;
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                // Leave only once the line is back high, so a held-low line reports one error.
                if (rxd_s) begin
                    state_nxt = RX_IDLE;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RX_IDLE;
            bit_cyc_cnt  <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            data_out     <= '0;
            rx_done_flag <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            rx_done_flag <= done_set;
            frame_err    <= err_set;
            if (cnt_clr || state == RX_IDLE || state == RX_BREAK) begin
                bit_cyc_cnt <= '0;
            end else begin
                bit_cyc_cnt <= bit_cyc_cnt + 1'b1;
            end
            if (idx_clr) begin
                bit_idx <= '0;
            end else if (idx_inc) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (shift_en) begin
                shreg[bit_idx] <= sample_bit;
            end
            if (done_set) begin
                data_out <= shreg;
            end
        end
    end

    assign rx_busy = (state != RX_IDLE);

endmodule
